// File: rtl/div_bcd_fmt_if.sv
// Bus between the 4-bit divider front end and the BCD formatter.
// Carries the capture request, the divider results and the formatted digits.
interface div_bcd_fmt_if #(
  parameter int W  = 4,
  parameter int ND = 2
);
  // start is a one-cycle request with no ready: it is taken only when the
  // formatter is in IDLE or DONE (busy=0) and silently dropped otherwise;
  // done marks the single cycle in which err/q_bcd/r_bcd are freshly valid.
  logic            start;
  logic [W-1:0]    dr;
  logic [W-1:0]    q;
  logic [W-1:0]    r;
  logic            busy;
  logic            done;
  logic            err;
  logic [4*ND-1:0] q_bcd;
  logic [4*ND-1:0] r_bcd;
  logic [1:0]      state_dbg;

  modport master (
    output start, dr, q, r,
    input  busy, done, err, q_bcd, r_bcd, state_dbg
  );

  modport slave (
    input  start, dr, q, r,
    output busy, done, err, q_bcd, r_bcd, state_dbg
  );
endinterface

// File: rtl/div_bcd_fmt.sv
// Captures divider quotient/remainder on start and converts both to packed BCD
// with a serial double-dabble sequencer (one bit per clock); flags divide-by-zero.
module div_bcd_fmt #(
  parameter int W  = 4,
  parameter int ND = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  div_bcd_fmt_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int SW = 4 * ND;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    q_bin;
  logic [W-1:0]    r_bin;
  logic [SW-1:0]   q_scr;
  logic [SW-1:0]   r_scr;
  logic [SW-1:0]   q_adj;
  logic [SW-1:0]   r_adj;
  logic [SW-1:0]   q_scr_nxt;
  logic [SW-1:0]   r_scr_nxt;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [SW-1:0]   q_bcd_q;
  logic [SW-1:0]   r_bcd_q;

  // Per-nibble add-3 correction; nibbles are independent, no carry between them.
  function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
    logic [SW-1:0] res;
    res = s;
    for (int i = 0; i < ND; i++) begin
      if (s[4*i +: 4] >= 4'd5) res[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  always_comb begin
    q_adj     = add3(q_scr);
    r_adj     = add3(r_scr);
    q_scr_nxt = {q_adj[SW-2:0], q_bin[W-1]};
    r_scr_nxt = {r_adj[SW-2:0], r_bin[W-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      q_bin   <= '0;
      r_bin   <= '0;
      q_scr   <= '0;
      r_scr   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      q_bcd_q <= '0;
      r_bcd_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
          if (bus.start) begin
            if (bus.dr != '0) begin
              q_bin  <= bus.q;
              r_bin  <= bus.r;
              q_scr  <= '0;
              r_scr  <= '0;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= CONV;
            end else begin
              // Divide-by-zero skips conversion and reports immediately.
              err_q   <= 1'b1;
              q_bcd_q <= '0;
              r_bcd_q <= '0;
              done_q  <= 1'b1;
              state   <= DONE;
            end
          end
        end
        CONV: begin
          q_scr <= q_scr_nxt;
          r_scr <= r_scr_nxt;
          q_bin <= q_bin << 1;
          r_bin <= r_bin << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            q_bcd_q <= q_scr_nxt;
            r_bcd_q <= r_scr_nxt;
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state   <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.q_bcd     = q_bcd_q;
  assign bus.r_bcd     = r_bcd_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_div_bcd_fmt.sv
// Directed bench for div_bcd_fmt: conversion values, latency, divide-by-zero,
// start while busy, back-to-back start and mid-conversion reset.
module tb_div_bcd_fmt;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   n;

  div_bcd_fmt_if #(.W(4), .ND(2)) bus ();

  div_bcd_fmt #(.W(4), .ND(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] d, input logic [3:0] qq, input logic [3:0] rr);
    bus.dr    = d;
    bus.q     = qq;
    bus.r     = rr;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.dr    = 4'($urandom_range(0, 15));
    bus.q     = 4'($urandom_range(0, 15));
    bus.r     = 4'($urandom_range(0, 15));
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int bc;
    int pulses;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.dr    = '0;
    bus.q     = '0;
    bus.r     = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_q_bcd", {24'd0, bus.q_bcd}, 32'h00);
    chk("rst_r_bcd", {24'd0, bus.r_bcd}, 32'h00);
    chk("rst_state", {30'd0, bus.state_dbg}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 7/2: q=3 r=1
    do_start(4'd2, 4'd3, 4'd1);
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(n);
    chk("t1_latency", n, 32'd4);
    chk("t1_done", {31'd0, bus.done}, 32'd1);
    chk("t1_q_bcd", {24'd0, bus.q_bcd}, 32'h03);
    chk("t1_r_bcd", {24'd0, bus.r_bcd}, 32'h01);
    chk("t1_err", {31'd0, bus.err}, 32'd0);
    tick();
    chk("t1_done_pulse", {31'd0, bus.done}, 32'd0);
    chk("t1_idle", {30'd0, bus.state_dbg}, 32'd0);

    // q=15: busy exactly 4 cycles
    do_start(4'd1, 4'd15, 4'd0);
    bc = 0;
    while (bus.busy && bc < 20) begin
      bc++;
      tick();
    end
    chk("t2_busy_cycles", bc, 32'd4);
    chk("t2_done", {31'd0, bus.done}, 32'd1);
    chk("t2_q_bcd", {24'd0, bus.q_bcd}, 32'h15);
    chk("t2_r_bcd", {24'd0, bus.r_bcd}, 32'h00);
    tick();

    // divide by zero
    do_start(4'd0, 4'd7, 4'd3);
    chk("t3_done", {31'd0, bus.done}, 32'd1);
    chk("t3_err", {31'd0, bus.err}, 32'd1);
    chk("t3_q_bcd", {24'd0, bus.q_bcd}, 32'h00);
    chk("t3_r_bcd", {24'd0, bus.r_bcd}, 32'h00);
    chk("t3_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("t3_done_pulse", {31'd0, bus.done}, 32'd0);
    chk("t3_err_held", {31'd0, bus.err}, 32'd1);
    do_start(4'd3, 4'd2, 4'd1);
    chk("t3_err_held_conv", {31'd0, bus.err}, 32'd1);
    chk("t3_q_hold_conv", {24'd0, bus.q_bcd}, 32'h00);
    wait_done(n);
    chk("t3_latency", n, 32'd4);
    chk("t3_err_clear", {31'd0, bus.err}, 32'd0);
    chk("t3_q_bcd2", {24'd0, bus.q_bcd}, 32'h02);
    chk("t3_r_bcd2", {24'd0, bus.r_bcd}, 32'h01);
    tick();

    // start during CONV is ignored
    do_start(4'd1, 4'd12, 4'd0);
    tick();
    do_start(4'd1, 4'd9, 4'd0);
    wait_done(n);
    chk("t4_latency", n, 32'd2);
    chk("t4_q_bcd", {24'd0, bus.q_bcd}, 32'h12);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    chk("t4_no_second_done", pulses, 32'd0);
    chk("t4_q_bcd_hold", {24'd0, bus.q_bcd}, 32'h12);

    // back-to-back start in DONE
    do_start(4'd1, 4'd13, 4'd0);
    wait_done(n);
    chk("t5_latency_a", n, 32'd4);
    chk("t5_q_bcd_a", {24'd0, bus.q_bcd}, 32'h13);
    do_start(4'd1, 4'd10, 4'd0);
    chk("t5_done_low", {31'd0, bus.done}, 32'd0);
    chk("t5_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(n);
    chk("t5_latency_b", n, 32'd4);
    chk("t5_q_bcd_b", {24'd0, bus.q_bcd}, 32'h10);
    tick();

    // reset mid-conversion
    do_start(4'd1, 4'd15, 4'd0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_busy", {31'd0, bus.busy}, 32'd0);
    chk("t6_done", {31'd0, bus.done}, 32'd0);
    chk("t6_err", {31'd0, bus.err}, 32'd0);
    chk("t6_q_bcd", {24'd0, bus.q_bcd}, 32'h00);
    chk("t6_r_bcd", {24'd0, bus.r_bcd}, 32'h00);
    chk("t6_state", {30'd0, bus.state_dbg}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_state_after", {30'd0, bus.state_dbg}, 32'd0);
    do_start(4'd4, 4'd3, 4'd2);
    wait_done(n);
    chk("t6_latency", n, 32'd4);
    chk("t6_q_bcd2", {24'd0, bus.q_bcd}, 32'h03);
    chk("t6_r_bcd2", {24'd0, bus.r_bcd}, 32'h02);
    chk("t6_err2", {31'd0, bus.err}, 32'd0);
    tick();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
